// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging ALU and long-latency results onto the regfile port, with busy scoreboard; define WB_FWD_EN for writeback-to-operand forwarding
module wb_arbiter #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int FDEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lu_issue,
    input  logic [4:0]      lu_issue_rd,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    input  logic [4:0]      dec_rd,
    output logic            hazard,
    output logic [NREG-1:0] busy_vec,
    output logic            rf_wr_en,
    output logic [4:0]      rf_w1,
    output logic [XLEN-1:0] rf_data,
    input  logic [XLEN-1:0] rf_rout1,
    input  logic [XLEN-1:0] rf_rout2,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2
);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = $clog2(FDEPTH + 1);

    logic [4:0]      q_rd   [FDEPTH];
    logic [XLEN-1:0] q_data [FDEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            alu_win, push, pop;
    logic [NREG-1:0] busy_nxt;

    assign lu_ready = count != CW'(FDEPTH);

    // ALU wins the port unless it targets x0; x0 results from the lu side never enter the FIFO
    always_comb begin
        alu_win = alu_valid && alu_rd != 5'd0;
        pop     = !alu_win && count != '0;
        push    = lu_valid && lu_ready && lu_rd != 5'd0;
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep count steady
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage, validity tracked by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= lu_rd;
            q_data[wr_ptr] <= lu_data;
        end
    end

    // scoreboard update: clear on head writeback, then set on issue so a same-reg set wins
    always_comb begin
        busy_nxt = busy_vec;
        if (pop) busy_nxt[q_rd[rd_ptr]] = 1'b0;
        if (lu_issue && lu_issue_rd != 5'd0) busy_nxt[lu_issue_rd] = 1'b1;
    end

    // registered regfile write port and scoreboard
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en <= 1'b0;
            rf_w1    <= '0;
            rf_data  <= '0;
            busy_vec <= '0;
        end else begin
            rf_wr_en <= alu_win || pop;
            rf_w1    <= alu_win ? alu_rd : pop ? q_rd[rd_ptr] : 5'd0;
            rf_data  <= alu_win ? alu_data : pop ? q_data[rd_ptr] : '0;
            busy_vec <= busy_nxt;
        end
    end

    assign hazard = (dec_rs1 != 5'd0 && busy_vec[dec_rs1]) ||
                    (dec_rs2 != 5'd0 && busy_vec[dec_rs2]) ||
                    (dec_rd != 5'd0 && busy_vec[dec_rd]);

`ifdef WB_FWD_EN
    assign op1 = (rf_wr_en && rf_w1 == dec_rs1 && dec_rs1 != 5'd0) ? rf_data : rf_rout1;
    assign op2 = (rf_wr_en && rf_w1 == dec_rs2 && dec_rs2 != 5'd0) ? rf_data : rf_rout2;
`else
    assign op1 = rf_rout1;
    assign op2 = rf_rout2;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table vectors, directed corner sequences and randomized run against a queue-based model
module tb_wb_arbiter;
    localparam int XLEN = 32, NREG = 32, FDEPTH = 2;
    logic clk = 1'b0;
    logic rst;
    logic alu_valid, lu_issue, lu_valid, lu_ready, hazard, rf_wr_en;
    logic [4:0] alu_rd, lu_issue_rd, lu_rd, dec_rs1, dec_rs2, dec_rd, rf_w1;
    logic [XLEN-1:0] alu_data, lu_data, rf_data, rf_rout1, rf_rout2, op1, op2;
    logic [NREG-1:0] busy_vec;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd), .lu_valid(lu_valid), .lu_ready(lu_ready),
        .lu_rd(lu_rd), .lu_data(lu_data), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .hazard(hazard), .busy_vec(busy_vec), .rf_wr_en(rf_wr_en), .rf_w1(rf_w1), .rf_data(rf_data),
        .rf_rout1(rf_rout1), .rf_rout2(rf_rout2), .op1(op1), .op2(op2)
    );

    int nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
    ent_t mq[$];
    logic [31:0] mbusy = '0;
    logic men = 1'b0;
    logic [4:0] mw1 = '0;
    logic [31:0] mdata = '0;

    function automatic logic m_hz();
        return (dec_rs1 != 0 && mbusy[dec_rs1]) || (dec_rs2 != 0 && mbusy[dec_rs2]) ||
               (dec_rd != 0 && mbusy[dec_rd]);
    endfunction

    function automatic logic [31:0] m_op(input logic [4:0] rs, input logic [31:0] rout);
`ifdef WB_FWD_EN
        return (men && mw1 == rs && rs != 0) ? mdata : rout;
`else
        return rout;
`endif
    endfunction

    task automatic m_step();
        bit rdy;
        ent_t h;
        rdy = mq.size() < FDEPTH;
        men = 1'b0;
        if (alu_valid && alu_rd != 0) begin
            men = 1'b1; mw1 = alu_rd; mdata = alu_data;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            men = 1'b1; mw1 = h.rd; mdata = h.d; mbusy[h.rd] = 1'b0;
        end
        if (lu_valid && rdy && lu_rd != 0) begin
            h.rd = lu_rd; h.d = lu_data;
            mq.push_back(h);
        end
        if (lu_issue && lu_issue_rd != 0) mbusy[lu_issue_rd] = 1'b1;
        if (rst) begin
            mq.delete(); mbusy = '0; men = 1'b0; mw1 = '0; mdata = '0;
        end
    endtask

    task automatic cyc(input string tag);
        #2;
        chk({tag, "_hazard"}, hazard, m_hz());
        chk({tag, "_lu_ready"}, lu_ready, mq.size() < FDEPTH);
        chk({tag, "_op1"}, op1, m_op(dec_rs1, rf_rout1));
        chk({tag, "_op2"}, op2, m_op(dec_rs2, rf_rout2));
        m_step();
        @(posedge clk); #1;
        chk({tag, "_rf_wr_en"}, rf_wr_en, men);
        if (men) begin
            chk({tag, "_rf_w1"}, rf_w1, mw1);
            chk({tag, "_rf_data"}, rf_data, mdata);
        end
        chk({tag, "_busy_vec"}, busy_vec, mbusy);
    endtask

    typedef struct {
        bit [31:0] av, ard, ad, li, lird, lv, lrd, ld, rs1, rs2, rd;
        bit [31:0] hz, rdy, en, w1, data, busy;
    } vec_t;
    localparam int NV = 24;
    vec_t tbl [NV];

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0; lu_issue = 0; lu_issue_rd = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        rf_rout1 = 0; rf_rout2 = 0;
    endtask

    initial begin
        vec_t t;
        //         av ard ad          li lird lv lrd ld      rs1 rs2 rd  hz rdy en w1  data         busy
        tbl[0]  = '{1, 5, 'hDEADBEEF, 0, 0,   0, 0,  0,      0,  0,  0,  0, 1,  1, 5,  'hDEADBEEF, 0};
        tbl[1]  = '{1, 0, 'h1234,     0, 0,   0, 0,  0,      0,  0,  0,  0, 1,  0, 0,  0,          0};
        tbl[2]  = '{0, 0, 0,          1, 7,   0, 0,  0,      7,  0,  0,  0, 1,  0, 0,  0,          'h80};
        tbl[3]  = '{0, 0, 0,          0, 0,   1, 7,  'h11,   7,  0,  0,  1, 1,  0, 0,  0,          'h80};
        tbl[4]  = '{0, 0, 0,          0, 0,   0, 0,  0,      7,  0,  0,  1, 1,  1, 7,  'h11,       0};
        tbl[5]  = '{0, 0, 0,          0, 0,   0, 0,  0,      7,  0,  0,  0, 1,  0, 0,  0,          0};
        tbl[6]  = '{1, 1, 'hA1,       0, 0,   1, 3,  'h33,   0,  0,  0,  0, 1,  1, 1,  'hA1,       0};
        tbl[7]  = '{1, 2, 'hA2,       0, 0,   1, 4,  'h44,   0,  0,  0,  0, 1,  1, 2,  'hA2,       0};
        tbl[8]  = '{1, 10, 'hA3,      0, 0,   1, 9,  'h99,   0,  0,  0,  0, 0,  1, 10, 'hA3,       0};
        tbl[9]  = '{1, 11, 'hA4,      0, 0,   1, 9,  'h99,   0,  0,  0,  0, 0,  1, 11, 'hA4,       0};
        tbl[10] = '{0, 0, 0,          0, 0,   1, 9,  'h99,   0,  0,  0,  0, 0,  1, 3,  'h33,       0};
        tbl[11] = '{0, 0, 0,          0, 0,   1, 9,  'h99,   0,  0,  0,  0, 1,  1, 4,  'h44,       0};
        tbl[12] = '{0, 0, 0,          0, 0,   0, 0,  0,      0,  0,  0,  0, 1,  1, 9,  'h99,       0};
        tbl[13] = '{0, 0, 0,          0, 0,   0, 0,  0,      0,  0,  0,  0, 1,  0, 0,  0,          0};
        tbl[14] = '{0, 0, 0,          0, 0,   1, 12, 'hC,    0,  0,  0,  0, 1,  0, 0,  0,          0};
        tbl[15] = '{0, 0, 0,          0, 0,   1, 13, 'hD,    0,  0,  0,  0, 1,  1, 12, 'hC,        0};
        tbl[16] = '{0, 0, 0,          0, 0,   0, 0,  0,      0,  0,  0,  0, 1,  1, 13, 'hD,        0};
        tbl[17] = '{0, 0, 0,          0, 0,   1, 14, 'hE,    0,  0,  0,  0, 1,  0, 0,  0,          0};
        tbl[18] = '{1, 0, 'hFF,       0, 0,   0, 0,  0,      0,  0,  0,  0, 1,  1, 14, 'hE,        0};
        tbl[19] = '{0, 0, 0,          0, 0,   1, 0,  'h5,    0,  0,  0,  0, 1,  0, 0,  0,          0};
        tbl[20] = '{0, 0, 0,          0, 0,   0, 0,  0,      0,  0,  0,  0, 1,  0, 0,  0,          0};
        tbl[21] = '{0, 0, 0,          1, 8,   1, 8,  'h88,   0,  8,  0,  0, 1,  0, 0,  0,          'h100};
        tbl[22] = '{0, 0, 0,          1, 8,   0, 0,  0,      0,  0,  8,  1, 1,  1, 8,  'h88,       'h100};
        tbl[23] = '{0, 0, 0,          0, 0,   0, 0,  0,      0,  0,  8,  1, 1,  0, 0,  0,          'h100};

        idle();
        rst = 1'b1;
        dec_rs1 = 7; dec_rs2 = 3; dec_rd = 9;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_wr_en", rf_wr_en, 0);
        chk("reset_busy_vec", busy_vec, 0);
        chk("reset_lu_ready", lu_ready, 1);
        chk("reset_hazard", hazard, 0);
        m_step();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            t = tbl[i];
            alu_valid = t.av[0]; alu_rd = t.ard[4:0]; alu_data = t.ad;
            lu_issue = t.li[0]; lu_issue_rd = t.lird[4:0];
            lu_valid = t.lv[0]; lu_rd = t.lrd[4:0]; lu_data = t.ld;
            dec_rs1 = t.rs1[4:0]; dec_rs2 = t.rs2[4:0]; dec_rd = t.rd[4:0];
            #2;
            chk($sformatf("tbl%0d_hazard", i), hazard, t.hz);
            chk($sformatf("tbl%0d_lu_ready", i), lu_ready, t.rdy);
            m_step();
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_rf_wr_en", i), rf_wr_en, t.en);
            if (t.en[0]) begin
                chk($sformatf("tbl%0d_rf_w1", i), rf_w1, t.w1);
                chk($sformatf("tbl%0d_rf_data", i), rf_data, t.data);
            end
            chk($sformatf("tbl%0d_busy_vec", i), busy_vec, t.busy);
        end

        for (int i = 0; i < 600; i++) begin
            alu_valid = $urandom_range(0, 2) == 0;
            alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
            lu_issue = $urandom_range(0, 3) == 0;
            lu_issue_rd = 5'($urandom_range(0, 31));
            lu_valid = $urandom_range(0, 1) == 1;
            lu_rd = 5'($urandom_range(0, 31)); lu_data = $urandom;
            dec_rs1 = ($urandom_range(0, 3) == 0) ? mw1 : 5'($urandom_range(0, 31));
            dec_rs2 = ($urandom_range(0, 3) == 0) ? mw1 : 5'($urandom_range(0, 31));
            dec_rd = 5'($urandom_range(0, 31));
            rf_rout1 = $urandom; rf_rout2 = $urandom;
            cyc($sformatf("rnd%0d", i));
        end

        idle();
        lu_issue = 1; lu_issue_rd = 20; lu_valid = 1; lu_rd = 20; lu_data = 'h2020;
        alu_valid = 1; alu_rd = 1; alu_data = 'h1;
        cyc("midrst_fill0");
        lu_issue_rd = 21; lu_rd = 21; lu_data = 'h2121; alu_rd = 2;
        cyc("midrst_fill1");
        rst = 1'b1; lu_issue = 0; lu_valid = 0;
        cyc("midrst_rst");
        chk("midrst_lu_ready", lu_ready, 1);
        chk("midrst_busy_vec", busy_vec, 0);
        rst = 1'b0; idle(); dec_rs1 = 20; dec_rs2 = 21;
        cyc("midrst_after");

        idle();
        alu_valid = 1; alu_rd = 6; alu_data = 'hA5;
        cyc("fwd_write");
        idle(); dec_rs1 = 6; rf_rout1 = 0; rf_rout2 = 'h77; dec_rs2 = 0;
        #1;
`ifdef WB_FWD_EN
        chk("fwd_op1", op1, 'hA5);
`else
        chk("fwd_op1", op1, 0);
`endif
        chk("fwd_op2", op2, 'h77);
        cyc("fwd_next");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
